mul_div_unit: RTL

Iterative 32-bit integer divider for MIPS DIV/DIVU. Sits in the EXE stage beside the single-cycle ALU. The ALU keeps returning zero for ALU op bits 12 (DIV) and 13 (DIVU); EXE instead launches this unit and stalls until the quotient and remainder are available. Results are written to LO (quotient) and HI (remainder) by the downstream pipeline.

---
 rtl/mul_div_pkg.sv | 18 +
 rtl/mul_div_unit_div_step.sv | 22 ++
 rtl/mul_div_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared types for the EXE-stage iterative divider (DIV/DIVU).
// Holds the FSM state encoding, the iteration count and the {q, r} result layout.
package mul_div_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [DIV_ITER-1:0] q;
        logic [DIV_ITER-1:0] r;
    } div_result_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         din,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    assign shifted = {rem, din};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // When the divisor fits, the true difference is below 2^W, so W bits suffice.
    assign diff     = shifted[W-1:0] - divisor;
    assign rem_next = q_bit ? diff : shifted[W-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after accept.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int DIV_W = DIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in_valid,
    output logic             div_in_ready,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] div_x,
    input  logic [DIV_W-1:0] div_y,
    input  logic             div_cancel,
    output logic             div_out_valid,
    input  logic             div_out_ready,
    output logic [DIV_W-1:0] div_q,
    output logic [DIV_W-1:0] div_r,
    output logic             div_busy
);

    localparam int CNT_W = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] abs_y;
    logic [DIV_W-1:0] dvd;
    logic [DIV_W-1:0] quo;
    logic [DIV_W-1:0] rem;
    logic             sign_q;
    logic             sign_r;
    div_result_t      result;

    logic [DIV_W-1:0] abs_x_in;
    logic [DIV_W-1:0] abs_y_in;
    logic [DIV_W-1:0] rem_next;
    logic             q_bit;
    logic             finish;
    logic [DIV_W-1:0] quo_fin;
    logic [DIV_W-1:0] rem_fin;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the input side is also vetoed by div_cancel. Once div_out_valid rises,
    // div_q/div_r hold until div_out_ready is seen or the operation is cancelled.
    assign div_in_ready  = (state == IDLE);
    assign div_out_valid = (state == DONE);
    assign div_busy      = (state != IDLE);
    assign div_q         = result.q;
    assign div_r         = result.r;

    assign abs_x_in = (div_signed && div_x[DIV_W-1]) ? -div_x : div_x;
    assign abs_y_in = (div_signed && div_y[DIV_W-1]) ? -div_y : div_y;

    div_step #(.W(DIV_W)) u_step (
        .rem      (rem),
        .din      (dvd[DIV_W-1]),
        .divisor  (abs_y),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

`ifdef DIV_ZERO_FAST_EN
    // A zero divisor yields all-ones magnitude quotient and |x| remainder, exactly
    // what the full iteration would produce, so it can finish on the first CALC cycle.
    assign finish  = (cnt == LAST_CNT) || (abs_y == '0);
    assign quo_fin = (abs_y == '0) ? '1 : quo;
    assign rem_fin = (abs_y == '0) ? dvd : rem;
`else
    assign finish  = (cnt == LAST_CNT);
    assign quo_fin = quo;
    assign rem_fin = rem;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            abs_y  <= '0;
            dvd    <= '0;
            quo    <= '0;
            rem    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else if (div_cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_in_valid) begin
                        state  <= CALC;
                        cnt    <= '0;
                        abs_y  <= abs_y_in;
                        dvd    <= abs_x_in;
                        quo    <= '0;
                        rem    <= '0;
                        sign_q <= div_signed & (div_x[DIV_W-1] ^ div_y[DIV_W-1]);
                        sign_r <= div_signed & div_x[DIV_W-1];
                    end
                end
                CALC: begin
                    if (finish) begin
                        state    <= DONE;
                        result.q <= sign_q ? -quo_fin : quo_fin;
                        result.r <= sign_r ? -rem_fin : rem_fin;
                    end else begin
                        rem <= rem_next;
                        quo <= {quo[DIV_W-2:0], q_bit};
                        dvd <= {dvd[DIV_W-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (div_out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
